expgolomb_dec: RTL and testbench

Exp-Golomb (order-0) code decoder that sits directly downstream of the `bits` bit-field extractor. It issues variable-length bit requests on the `bits` request port and consumes the `pushout`/`lenout`/`dataout` responses. It returns one decoded unsigned (ue) or signed (se) value per codeword on a valid/ready output. Malformed streams raise a sticky error.

---
 rtl/expgolomb_dec.sv | 165 ++++++++++++++++
 tb/tb_expgolomb_dec.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expgolomb_dec.sv
// -----------------------------------------------------------------------------
// expgolomb_dec
// Order-0 Exp-Golomb decoder sitting behind the `bits` field extractor.
// Pulls the unary prefix one bit at a time, then the N-bit suffix in a single
// request, and presents one ue/se value per codeword on a valid/ready port.
// Malformed streams or unexpected response strobes raise a sticky error.
//
// Ports
//   clock_i      clock, all logic on posedge
//   reset_i      synchronous active-high reset
//   run_i        allow a new codeword to start
//   signedin_i   se(v) mapping select, sampled when a codeword starts
//   reqin_o      one-cycle bit request to `bits`
//   reqlen_o     requested bit count (1..15), valid with reqin_o
//   bitpush_i    response strobe from `bits`
//   bitlen_i     response length
//   bitdata_i    response bits, right-justified, first stream bit is MSB
//   pushcode_o   decoded value valid
//   codeready_i  downstream accept
//   codeout_o    decoded value (ue unsigned / se two's complement)
//   zeros_o      prefix zero count of the presented codeword
//   err_o        sticky error, cleared only by reset
// -----------------------------------------------------------------------------
module expgolomb_dec #(
    parameter int MAXZ = 15
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic        signedin_i,
    output logic        reqin_o,
    output logic [3:0]  reqlen_o,
    input  logic        bitpush_i,
    input  logic [3:0]  bitlen_i,
    input  logic [14:0] bitdata_i,
    output logic        pushcode_o,
    input  logic        codeready_i,
    output logic [15:0] codeout_o,
    output logic [3:0]  zeros_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREQ  = 3'd1;
    localparam logic [2:0] S_PWAIT = 3'd2;
    localparam logic [2:0] S_SREQ  = 3'd3;
    localparam logic [2:0] S_SWAIT = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [4:0]  nz_q, nz_d;       // 5 bits so the MAXZ+1 overflow is visible
    logic        sgn_q, sgn_d;
    logic [15:0] code_q, code_d;
    logic [3:0]  zeros_q, zeros_d;
    logic        reqin_q, push_q, err_q;
    logic [3:0]  reqlen_q;

    // k = (2^N - 1) + suffix, computed at 17 bits; max 65534 so k[16] is 0.
    logic [16:0] pfx, sfx, kval;
    logic [15:0] half, code_se;
    logic [4:0]  nz_inc;

    assign pfx     = (17'd1 << nz_q) - 17'd1;
    assign sfx     = {2'b00, bitdata_i} & pfx;
    assign kval    = pfx + sfx;
    assign half    = kval[16:1];
    // odd k -> +(k+1)/2, even k -> -(k/2)
    assign code_se = kval[0] ? (half + 16'd1) : (16'd0 - half);
    assign nz_inc  = nz_q + 5'd1;

    always_comb begin
        state_d = state_q;
        nz_d    = nz_q;
        sgn_d   = sgn_q;
        code_d  = code_q;
        zeros_d = zeros_q;
        case (state_q)
            S_IDLE: begin
                if (bitpush_i) state_d = S_ERR;
                else if (run_i) begin
                    sgn_d   = signedin_i;
                    nz_d    = 5'd0;
                    state_d = S_PREQ;
                end
            end
            S_PREQ: state_d = bitpush_i ? S_ERR : S_PWAIT;
            S_PWAIT: begin
                if (bitpush_i) begin
                    if (bitlen_i != 4'd1) state_d = S_ERR;
                    else if (!bitdata_i[0]) begin
                        nz_d    = nz_inc;
                        state_d = (nz_inc > 5'(MAXZ)) ? S_ERR : S_PREQ;
                    end else if (nz_q == 5'd0) begin
                        code_d  = 16'd0;
                        zeros_d = 4'd0;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_SREQ;
                    end
                end
            end
            S_SREQ: state_d = bitpush_i ? S_ERR : S_SWAIT;
            S_SWAIT: begin
                if (bitpush_i) begin
                    if (bitlen_i != nz_q[3:0]) state_d = S_ERR;
                    else begin
                        code_d  = sgn_q ? code_se : kval[15:0];
                        zeros_d = nz_q[3:0];
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bitpush_i) state_d = S_ERR;
                else if (codeready_i) begin
                    // chain straight into the next prefix when run is high
                    if (run_i) begin
                        sgn_d   = signedin_i;
                        nz_d    = 5'd0;
                        state_d = S_PREQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Outputs are registered off the next state so they line up with it.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            nz_q     <= 5'd0;
            sgn_q    <= 1'b0;
            code_q   <= 16'd0;
            zeros_q  <= 4'd0;
            reqin_q  <= 1'b0;
            reqlen_q <= 4'd0;
            push_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nz_q     <= nz_d;
            sgn_q    <= sgn_d;
            code_q   <= code_d;
            zeros_q  <= zeros_d;
            reqin_q  <= (state_d == S_PREQ) || (state_d == S_SREQ);
            reqlen_q <= (state_d == S_PREQ) ? 4'd1 :
                        (state_d == S_SREQ) ? nz_d[3:0] : 4'd0;
            push_q   <= (state_d == S_OUT);
            err_q    <= (state_d == S_ERR);
        end
    end

    assign reqin_o    = reqin_q;
    assign reqlen_o   = reqlen_q;
    assign pushcode_o = push_q;
    assign codeout_o  = code_q;
    assign zeros_o    = zeros_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_expgolomb_dec.sv
module tb_expgolomb_dec;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        run_i = 1'b0;
    logic        signedin_i = 1'b0;
    logic        reqin_o;
    logic [3:0]  reqlen_o;
    logic        bitpush_i = 1'b0;
    logic [3:0]  bitlen_i = 4'd0;
    logic [14:0] bitdata_i = 15'd0;
    logic        pushcode_o;
    logic        codeready_i = 1'b0;
    logic [15:0] codeout_o;
    logic [3:0]  zeros_o;
    logic        err_o;

    expgolomb_dec #(.MAXZ(15)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .run_i(run_i), .signedin_i(signedin_i),
        .reqin_o(reqin_o), .reqlen_o(reqlen_o), .bitpush_i(bitpush_i),
        .bitlen_i(bitlen_i), .bitdata_i(bitdata_i), .pushcode_o(pushcode_o),
        .codeready_i(codeready_i), .codeout_o(codeout_o), .zeros_o(zeros_o),
        .err_o(err_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [15:0] code;
        logic [3:0]  z;
        bit          sgn;
    } exp_t;

    bit   sq[$];        // bit stream held by the `bits` model
    exp_t expq[$];      // expected values in codeword order

    int n_cmp = 0;
    int n_bad = 0;

    // `bits` model and handshake state
    bit          pend = 0;
    int          pend_len = 0;
    int          lat_cnt = 0;
    int          lat_max = 1;
    bit          bad_len3 = 0;
    int          cr_mode = 1;   // 0 hold low, 1 hold high, 2 random
    bit          run_rand = 0;
    bit          stall_prev = 0;
    logic [15:0] prev_code;
    logic [3:0]  prev_z;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Order-0 Exp-Golomb encoder: N zeros then the N+1 bits of k+1.
    task automatic add_cw(input int k, input bit sgn, input logic [15:0] ecode);
        int m, n;
        exp_t e;
        m = k + 1;
        n = 0;
        while ((m >> (n + 1)) != 0) n++;
        for (int i = 0; i < n; i++) sq.push_back(1'b0);
        for (int i = n; i >= 0; i--) sq.push_back(1'((m >> i) & 1));
        e.code = ecode;
        e.z    = 4'(n);
        e.sgn  = sgn;
        expq.push_back(e);
    endtask

    function automatic logic [15:0] ref_map(input int k, input bit sgn);
        if (!sgn) return 16'(k);
        if ((k % 2) == 1) return 16'((k + 1) / 2);
        return 16'(-(k / 2));
    endfunction

    // One clock: model `bits`, drive codeready/run/signedin, score transfers.
    task automatic cyc();
        bit resp_now;
        bit xfer;
        int data;
        exp_t e;
        @(posedge clock_i);
        #1;
        if (stall_prev)
            chk("stall_hold", {11'd0, pushcode_o, codeout_o, zeros_o}, {11'd0, 1'b1, prev_code, prev_z});
        bitpush_i = 1'b0;
        resp_now  = 0;
        if (pend) begin
            if (lat_cnt > 0) lat_cnt--;
            else if (sq.size() >= pend_len) begin
                data = 0;
                for (int i = 0; i < pend_len; i++) data = (data << 1) | int'(sq.pop_front());
                bitpush_i = 1'b1;
                bitlen_i  = (bad_len3 && pend_len == 3) ? 4'd2 : 4'(pend_len);
                bitdata_i = 15'(data);
                pend      = 0;
                resp_now  = 1;
            end
        end
        if (reqin_o) begin
            chk("one_outstanding", {29'd0, pend, resp_now, pushcode_o}, 32'd0);
            pend     = 1;
            pend_len = int'(reqlen_o);
            lat_cnt  = $urandom_range(1, lat_max) - 1;
        end
        codeready_i = (cr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(cr_mode);
        xfer = pushcode_o && codeready_i;
        if (xfer) begin
            if (expq.size() == 0) chk("extra_output", 32'd1, 32'd0);
            else begin
                e = expq.pop_front();
                chk("codeout", 32'(codeout_o), 32'(e.code));
                chk("zeros", 32'(zeros_o), 32'(e.z));
            end
        end
        stall_prev = pushcode_o && !codeready_i;
        prev_code  = codeout_o;
        prev_z     = zeros_o;
        if (run_rand) run_i = (expq.size() > 0) && ($urandom_range(0, 4) != 0);
        signedin_i = (expq.size() > 0) ? expq[0].sgn : 1'b0;
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        run_i      = 1'b0;
        bitpush_i  = 1'b0;
        pend       = 0;
        bad_len3   = 0;
        run_rand   = 0;
        stall_prev = 0;
        sq.delete();
        expq.delete();
        cyc();
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && expq.size() > 0; i++) cyc();
        chk("drain_left", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        bit found;
        int k, n;
        logic [15:0] hold_code;
        logic [3:0]  hold_z;

        // reset state
        do_reset();
        cyc();
        chk("rst_reqin", 32'(reqin_o), 0);
        chk("rst_reqlen", 32'(reqlen_o), 0);
        chk("rst_push", 32'(pushcode_o), 0);
        chk("rst_code", 32'(codeout_o), 0);
        chk("rst_zeros", 32'(zeros_o), 0);
        chk("rst_err", 32'(err_o), 0);

        // ue basics with start latency and no-bubble check
        do_reset();
        lat_max = 1; cr_mode = 1;
        add_cw(0, 0, 16'd0);
        add_cw(1, 0, 16'd1);
        add_cw(2, 0, 16'd2);
        add_cw(4, 0, 16'd4);
        signedin_i = 1'b0;
        run_i = 1'b1;
        cyc();
        cyc();
        chk("first_not_yet", 32'(pushcode_o), 0);
        cyc();
        chk("first_at_3", 32'(pushcode_o), 1);
        cyc();
        chk("no_bubble_req", 32'(reqin_o), 1);
        drain(200);

        // maximum code
        do_reset();
        add_cw(65534, 0, 16'hFFFE);
        run_i = 1'b1;
        drain(200);
        chk("max_err", 32'(err_o), 0);

        // 16 zero prefix overflows MAXZ
        do_reset();
        for (int i = 0; i < 16; i++) sq.push_back(1'b0);
        run_i = 1'b1;
        for (int i = 0; i < 200 && !err_o; i++) cyc();
        chk("maxz_err", 32'(err_o), 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin cyc(); if (reqin_o) cnt++; end
        chk("maxz_noreq", cnt, 0);

        // se mapping
        do_reset();
        add_cw(1, 1, 16'h0001);
        add_cw(2, 1, 16'hFFFF);
        add_cw(3, 1, 16'h0002);
        add_cw(4, 1, 16'hFFFE);
        signedin_i = 1'b1;
        run_i = 1'b1;
        drain(200);

        // backpressure
        do_reset();
        cr_mode = 0;
        add_cw(5, 0, 16'd5);
        add_cw(7, 0, 16'd7);
        run_i = 1'b1;
        for (int i = 0; i < 100 && !pushcode_o; i++) cyc();
        chk("bp_present", 32'(pushcode_o), 1);
        hold_code = codeout_o;
        hold_z    = zeros_o;
        chk("bp_value", 32'(hold_code), 5);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (reqin_o || !pushcode_o || codeout_o != hold_code || zeros_o != hold_z) cnt++;
        end
        chk("bp_stable", cnt, 0);
        cr_mode = 1;
        cyc();
        cyc();
        chk("bp_one_xfer", 32'(pushcode_o), 0);
        chk("bp_next_req", 32'(reqin_o), 1);
        drain(200);

        // response length mismatch on a 3-bit suffix
        do_reset();
        add_cw(7, 0, 16'd7);
        bad_len3 = 1;
        run_i = 1'b1;
        for (int i = 0; i < 100 && !err_o; i++) cyc();
        chk("badlen_err", 32'(err_o), 1);
        chk("badlen_noout", 32'(expq.size()), 1);

        // spurious bitpush in IDLE
        do_reset();
        cyc();
        bitpush_i = 1'b1; bitlen_i = 4'd1; bitdata_i = 15'd0;
        cyc();
        chk("idle_push_err", 32'(err_o), 1);
        run_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cyc(); if (reqin_o) cnt++; end
        chk("idle_push_noreq", cnt, 0);
        chk("idle_push_sticky", 32'(err_o), 1);

        // reset during SWAIT with a response in the same cycle
        do_reset();
        lat_max = 1; cr_mode = 1;
        add_cw(1, 0, 16'd1);
        add_cw(4, 0, 16'd4);
        run_i = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (reqin_o && reqlen_o == 4'd2) found = 1;
        end
        chk("swait_reached", 32'(found), 1);
        cyc();
        reset_i = 1'b1;
        run_i = 1'b0;
        expq.delete();
        cyc();
        chk("midrst_outs", {10'd0, reqin_o, reqlen_o, pushcode_o, codeout_o, zeros_o, err_o}, 32'd0);
        reset_i = 1'b0;
        pend = 0;
        sq.delete();
        stall_prev = 0;
        add_cw(2, 0, 16'd2);
        run_i = 1'b1;
        drain(200);

        // randomized mix of ue/se codewords, latencies, backpressure, run gaps
        do_reset();
        lat_max = 4; cr_mode = 2;
        for (int i = 0; i < 150; i++) begin
            bit s;
            n = $urandom_range(0, 15);
            k = (1 << n) - 1 + int'($urandom_range(0, (1 << n) - 1));
            s = 1'($urandom_range(0, 1));
            add_cw(k, s, ref_map(k, s));
        end
        run_rand = 1;
        signedin_i = expq[0].sgn;
        run_i = 1'b1;
        drain(30000);
        chk("rand_err", 32'(err_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
